tx_frame_gen: RTL and testbench



---
 rtl/tx_frame_gen.sv | 172 +++++++++++++++++
 tb/tb_tx_frame_gen.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_frame_gen.sv
// Bit-serial test-frame transmitter: silence, sync, silence, header, silence, PRBS payload.
// Optional data-bit error injection is compiled in when TX_ERR_INJECT_EN is defined.
module tx_frame_gen #(
  parameter int          SILENCE_BITS = 100,
  parameter int          SYNC_BITS    = 64,
  parameter logic [63:0] SYNC_WORD    = 64'hA5A5_F0F0_3C3C_0FF1,
  parameter int          HEADER_BITS  = 384
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tx_en,
  input  logic        start,
  input  logic        cont_mode,
  input  logic [2:0]  rate_sel,
  input  logic [1:0]  prbs_sel,
  input  logic        bit_tick,
`ifdef TX_ERR_INJECT_EN
  input  logic        err_inj_arm,
  input  logic [31:0] err_inj_idx,
  output logic        err_inj_done,
`endif
  output logic        tx_bit,
  output logic        tx_bit_vld,
  output logic        tx_busy,
  output logic        frame_done,
  output logic [2:0]  seg,
  output logic [31:0] frame_cnt,
  output logic [31:0] data_idx
);

  typedef enum logic [2:0] {
    IDLE = 3'd0, SIL1 = 3'd1, SYNC = 3'd2, SIL2 = 3'd3,
    HDR  = 3'd4, SIL3 = 3'd5, DATA = 3'd6, DONE = 3'd7
  } state_t;

  state_t      state, next_seg;
  logic [31:0] bit_cnt, seg_len, data_len;
  logic [30:0] lfsr, lfsr_nxt;
  logic [2:0]  rate_l;
  logic [1:0]  prbs_l;
  logic [7:0]  hdr_cfg;
  logic [5:0]  sync_idx;
  logic        prbs_out, seg_bit, seg_last, start_req, flip;

`ifdef TX_ERR_INJECT_EN
  logic err_arm_l;
  assign flip = err_arm_l && (data_idx == err_inj_idx);
`else
  assign flip = 1'b0;
`endif

  assign seg       = state;
  assign tx_busy   = (state != IDLE) && (state != DONE);
  assign start_req = tx_en && (((state == IDLE) && start) || ((state == DONE) && cont_mode));
  assign hdr_cfg   = {rate_l, prbs_l, 3'b000};
  assign sync_idx  = 6'(SYNC_BITS - 1) - bit_cnt[5:0];
  assign seg_last  = (bit_cnt == seg_len - 32'd1);

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    lfsr_nxt = lfsr;
    prbs_out = lfsr[6];
    case (prbs_l)
      2'd0:    lfsr_nxt[6:0]  = {lfsr[5:0], lfsr[6] ^ lfsr[5]};
      2'd1:    begin prbs_out = lfsr[8];  lfsr_nxt[8:0]  = {lfsr[7:0],  lfsr[8] ^ lfsr[4]};   end
      2'd2:    begin prbs_out = lfsr[14]; lfsr_nxt[14:0] = {lfsr[13:0], lfsr[14] ^ lfsr[13]}; end
      default: begin prbs_out = lfsr[30]; lfsr_nxt       = {lfsr[29:0], lfsr[30] ^ lfsr[27]}; end
    endcase
  end

  always_comb begin
    case (rate_l)
      3'd1:    data_len = 32'd40000;
      3'd2:    data_len = 32'd80000;
      3'd3:    data_len = 32'd160000;
      3'd4:    data_len = 32'd320000;
      3'd5:    data_len = 32'd650000;
      default: data_len = 32'd20000;
    endcase
  end

  always_comb begin
    seg_len  = 32'(SILENCE_BITS);
    next_seg = IDLE;
    seg_bit  = 1'b0;
    case (state)
      SIL1: next_seg = SYNC;
      SYNC: begin seg_len = 32'(SYNC_BITS); next_seg = SIL2; seg_bit = SYNC_WORD[sync_idx]; end
      SIL2: next_seg = HDR;
      HDR: begin
        seg_len  = 32'(HEADER_BITS);
        next_seg = SIL3;
        // Header: frame count, then {rate, prbs, 000}, then an alternating 0/1 fill.
        if (bit_cnt < 32'd32)      seg_bit = frame_cnt[5'd31 - bit_cnt[4:0]];
        else if (bit_cnt < 32'd40) seg_bit = hdr_cfg[3'd7 - bit_cnt[2:0]];
        else                       seg_bit = bit_cnt[0];
      end
      SIL3:    next_seg = DATA;
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      tx_bit     <= 1'b0;
      tx_bit_vld <= 1'b0;
      frame_done <= 1'b0;
      frame_cnt  <= '0;
      data_idx   <= '0;
      bit_cnt    <= '0;
      lfsr       <= '1;
      rate_l     <= '0;
      prbs_l     <= '0;
`ifdef TX_ERR_INJECT_EN
      err_arm_l    <= 1'b0;
      err_inj_done <= 1'b0;
`endif
    end else begin
      tx_bit_vld <= 1'b0;
      frame_done <= 1'b0;
`ifdef TX_ERR_INJECT_EN
      err_inj_done <= 1'b0;
`endif
      if (!tx_en) begin
        state <= IDLE;
      end else if (start_req) begin
        rate_l    <= rate_sel;
        prbs_l    <= prbs_sel;
        frame_cnt <= frame_cnt + 32'd1;
        lfsr      <= '1;
        bit_cnt   <= '0;
        data_idx  <= '0;
        state     <= SIL1;
`ifdef TX_ERR_INJECT_EN
        err_arm_l <= err_inj_arm;
`endif
      end else begin
        case (state)
          IDLE: ;
          DONE: state <= IDLE;
          DATA: if (bit_tick) begin
            tx_bit     <= prbs_out ^ flip;
            tx_bit_vld <= 1'b1;
            lfsr       <= lfsr_nxt;
`ifdef TX_ERR_INJECT_EN
            err_inj_done <= flip;
`endif
            if (data_idx == data_len - 32'd1) begin
              frame_done <= 1'b1;
              state      <= DONE;
            end else begin
              data_idx <= data_idx + 32'd1;
            end
          end
          default: if (bit_tick) begin
            tx_bit     <= seg_bit;
            tx_bit_vld <= 1'b1;
            if (seg_last) begin
              bit_cnt <= '0;
              state   <= next_seg;
            end else begin
              bit_cnt <= bit_cnt + 32'd1;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tx_frame_gen.sv
// Self-checking bench for tx_frame_gen: a queue of expected bits built from the frame rules,
// checked against every tx_bit_vld, plus directed checks on control outputs.
module tb_tx_frame_gen;

  localparam int          SIL = 100;
  localparam int          SB  = 64;
  localparam logic [63:0] SW  = 64'hA5A5_F0F0_3C3C_0FF1;
  localparam int          HB  = 384;

  logic        clk = 1'b0;
  logic        rst, tx_en, start, cont_mode, bit_tick;
  logic [2:0]  rate_sel;
  logic [1:0]  prbs_sel;
  logic        tx_bit, tx_bit_vld, tx_busy, frame_done;
  logic [2:0]  seg;
  logic [31:0] frame_cnt, data_idx;
`ifdef TX_ERR_INJECT_EN
  logic        err_inj_done;
`endif

  int errors = 0;
  int checks = 0;
  int tick_mode = 0;
  logic [1:0] exp_q[$];   // {expected bit, expected frame_done}

  tx_frame_gen dut (
    .clk(clk), .rst(rst), .tx_en(tx_en), .start(start), .cont_mode(cont_mode),
    .rate_sel(rate_sel), .prbs_sel(prbs_sel), .bit_tick(bit_tick),
`ifdef TX_ERR_INJECT_EN
    .err_inj_arm(1'b0), .err_inj_idx(32'd0), .err_inj_done(err_inj_done),
`endif
    .tx_bit(tx_bit), .tx_bit_vld(tx_bit_vld), .tx_busy(tx_busy), .frame_done(frame_done),
    .seg(seg), .frame_cnt(frame_cnt), .data_idx(data_idx)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int data_len(input logic [2:0] r);
    case (r)
      3'd1: return 40000;
      3'd2: return 80000;
      3'd3: return 160000;
      3'd4: return 320000;
      3'd5: return 650000;
      default: return 20000;
    endcase
  endfunction

  // One PRBS step: output is the top bit of the active width, feedback goes in at bit 0.
  task automatic prbs_next(input logic [1:0] p, inout logic [31:0] s, output logic o);
    int w, t;
    case (p)
      2'd0: begin w = 7;  t = 6;  end
      2'd1: begin w = 9;  t = 5;  end
      2'd2: begin w = 15; t = 14; end
      default: begin w = 31; t = 28; end
    endcase
    o = s[w-1];
    s = {s[30:0], s[w-1] ^ s[t-1]};
  endtask

  task automatic push_frame(input logic [31:0] cnt, input logic [2:0] r, input logic [1:0] p,
                            input int limit);
    int len, n;
    logic [7:0]  cfg;
    logic [31:0] s;
    logic o;
    len = data_len(r);
    n   = (limit < len) ? limit : len;
    cfg = {r, p, 3'b000};
    s   = '1;
    repeat (SIL) exp_q.push_back(2'b00);
    for (int k = 0; k < SB; k++) exp_q.push_back({SW[SB-1-k], 1'b0});
    repeat (SIL) exp_q.push_back(2'b00);
    for (int k = 0; k < HB; k++) begin
      if (k < 32)      exp_q.push_back({cnt[31-k], 1'b0});
      else if (k < 40) exp_q.push_back({cfg[39-k], 1'b0});
      else             exp_q.push_back({1'(k % 2), 1'b0});
    end
    repeat (SIL) exp_q.push_back(2'b00);
    for (int i = 0; i < n; i++) begin
      prbs_next(p, s, o);
      exp_q.push_back({o, 1'(i == len - 1)});
    end
  endtask

  task automatic pin_prbs(input logic [1:0] p, input int nbits, input logic [31:0] exp,
                          input string name);
    logic [31:0] s, word;
    logic o;
    s = '1;
    word = '0;
    for (int i = 0; i < nbits; i++) begin
      prbs_next(p, s, o);
      word = {word[30:0], o};
    end
    check(name, word, exp);
  endtask

  task automatic wait_seg(input logic [2:0] s, input int budget, input string name);
    int n = 0;
    while (seg !== s && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, {29'd0, seg}, {29'd0, s});
  endtask

  task automatic wait_idx(input logic [31:0] idx, input int budget, input string name);
    int n = 0;
    while (!(seg === 3'd6 && data_idx === idx) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, data_idx, idx);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_tx_bit"},     {31'd0, tx_bit}, 32'd0);
    check({tag, "_tx_bit_vld"}, {31'd0, tx_bit_vld}, 32'd0);
    check({tag, "_tx_busy"},    {31'd0, tx_busy}, 32'd0);
    check({tag, "_frame_done"}, {31'd0, frame_done}, 32'd0);
    check({tag, "_seg"},        {29'd0, seg}, 32'd0);
    check({tag, "_frame_cnt"},  frame_cnt, 32'd0);
    check({tag, "_data_idx"},   data_idx, 32'd0);
  endtask

  task automatic abort_frame(input logic [31:0] cnt, input string tag);
    tx_en = 1'b0;
    @(negedge clk);
    check({tag, "_seg"},        {29'd0, seg}, 32'd0);
    check({tag, "_busy"},       {31'd0, tx_busy}, 32'd0);
    check({tag, "_done"},       {31'd0, frame_done}, 32'd0);
    check({tag, "_vld"},        {31'd0, tx_bit_vld}, 32'd0);
    check({tag, "_frame_cnt"},  frame_cnt, cnt);
    exp_q.delete();
    tx_en = 1'b1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  always @(negedge clk) begin
    bit_tick = (tick_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
  end

  // Every emitted bit is matched against the model queue; frame_done is only legal with a bit.
  always @(negedge clk) begin
    logic [1:0] e;
    if (rst === 1'b0) begin
      if (tx_bit_vld) begin
        if (exp_q.size() == 0) check("unexpected_vld", {31'd0, tx_bit_vld}, 32'd0);
        else begin
          e = exp_q.pop_front();
          check("tx_bit", {31'd0, tx_bit}, {31'd0, e[1]});
          check("frame_done", {31'd0, frame_done}, {31'd0, e[0]});
        end
      end else begin
        check("done_without_vld", {31'd0, frame_done}, 32'd0);
      end
    end
  end

  initial begin
    logic [31:0] hdr_word;
    rst = 1'b1; tx_en = 1'b0; start = 1'b0; cont_mode = 1'b0;
    rate_sel = 3'd0; prbs_sel = 2'd0;

    // Each sequence from the all-ones seed: w ones, then a zero.
    pin_prbs(2'd0, 8,  32'h0000_00FE, "pin_prbs7");
    pin_prbs(2'd1, 10, 32'h0000_03FE, "pin_prbs9");
    pin_prbs(2'd2, 16, 32'h0000_FFFE, "pin_prbs15");
    pin_prbs(2'd3, 32, 32'hFFFF_FFFE, "pin_prbs31");

    repeat (3) @(negedge clk);
    check_reset_values("reset");
    rst = 1'b0;
    tx_en = 1'b1;
    repeat (5) @(negedge clk);
    check("idle_seg", {29'd0, seg}, 32'd0);

    // Frame 1: PRBS7, 20000 data bits, full-rate ticks.
    push_frame(32'd1, 3'd0, 2'd0, 1 << 30);
    hdr_word = '0;
    for (int k = 0; k < 32; k++) hdr_word = {hdr_word[30:0], exp_q[2*SIL + SB + k][1]};
    check("pin_header_cnt1", hdr_word, 32'd1);
    pulse_start();
    check("f1_seg_sil1", {29'd0, seg}, 32'd1);
    check("f1_busy", {31'd0, tx_busy}, 32'd1);
    check("f1_frame_cnt", frame_cnt, 32'd1);
    check("f1_data_idx", data_idx, 32'd0);
    wait_seg(3'd7, 25000, "f1_reach_done");
    check("f1_last_idx", data_idx, 32'd19999);
    check("f1_done_pulse", {31'd0, frame_done}, 32'd1);
    @(negedge clk);
    check("f1_back_idle", {29'd0, seg}, 32'd0);
    check("f1_idle_busy", {31'd0, tx_busy}, 32'd0);
    check("f1_drained", exp_q.size(), 32'd0);

    // Frames 2-4 chained by cont_mode; frame 4 picks up new rate/prbs and is aborted.
    cont_mode = 1'b1;
    push_frame(32'd2, 3'd0, 2'd0, 1 << 30);
    push_frame(32'd3, 3'd0, 2'd0, 1 << 30);
    push_frame(32'd4, 3'd5, 2'd3, 1000);
    pulse_start();
    check("f2_frame_cnt", frame_cnt, 32'd2);
    wait_seg(3'd7, 25000, "f2_reach_done");
    @(negedge clk);
    check("f3_auto_start", {29'd0, seg}, 32'd1);
    check("f3_frame_cnt", frame_cnt, 32'd3);
    rate_sel = 3'd5;
    prbs_sel = 2'd3;
    wait_seg(3'd7, 25000, "f3_reach_done");
    @(negedge clk);
    check("f4_auto_start", {29'd0, seg}, 32'd1);
    check("f4_frame_cnt", frame_cnt, 32'd4);
    cont_mode = 1'b0;
    wait_idx(32'd500, 3000, "f4_reach_idx500");
    abort_frame(32'd4, "f4_abort");

    // Frames 5 and 6: PRBS9 and PRBS15 under irregular ticks, aborted mid-payload.
    tick_mode = 1;
    rate_sel = 3'd6;
    prbs_sel = 2'd1;
    push_frame(32'd5, 3'd6, 2'd1, 1000);
    pulse_start();
    check("f5_frame_cnt", frame_cnt, 32'd5);
    wait_idx(32'd300, 8000, "f5_reach_idx300");
    abort_frame(32'd5, "f5_abort");

    rate_sel = 3'd7;
    prbs_sel = 2'd2;
    push_frame(32'd6, 3'd7, 2'd2, 1000);
    pulse_start();
    wait_idx(32'd300, 8000, "f6_reach_idx300");
    abort_frame(32'd6, "f6_abort");

    // Frame 7: synchronous reset in the middle of the header.
    tick_mode = 0;
    rate_sel = 3'd2;
    prbs_sel = 2'd0;
    push_frame(32'd7, 3'd2, 2'd0, 10);
    pulse_start();
    wait_seg(3'd4, 2000, "f7_reach_hdr");
    repeat (50) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_reset_values("midrst");
    exp_q.delete();
    rst = 1'b0;
    repeat (10) @(negedge clk);
    check("post_rst_idle", {29'd0, seg}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
